// File: rtl/serial_result_collector_if.sv
// serial_result_collector_if
//   Bundles the serial-input and result-output signals of the collector.
//   Ports (from the collector's point of view, modport slave):
//     sin, carry_in, bit_vld, frame_start  serial frame input
//     res_data[WIDTH:0], res_vld, res_rdy  parallel result handshake
//     clr_err, overflow, frame_err, busy   status / error flags
//   The master modport is the producer/consumer side.
interface serial_result_collector_if #(
  parameter int WIDTH = 4
) ();
  logic             sin;
  logic             carry_in;
  logic             bit_vld;
  logic             frame_start;
  logic [WIDTH:0]   res_data;
  logic             res_vld;
  logic             res_rdy;
  logic             clr_err;
  logic             overflow;
  logic             frame_err;
  logic             busy;

  modport master (
    output sin, carry_in, bit_vld, frame_start, res_rdy, clr_err,
    input  res_data, res_vld, overflow, frame_err, busy
  );

  modport slave (
    input  sin, carry_in, bit_vld, frame_start, res_rdy, clr_err,
    output res_data, res_vld, overflow, frame_err, busy
  );
endinterface

// File: rtl/serial_result_collector.sv
// serial_result_collector
//   Collects an LSB-first sum bitstream plus the final carry from the
//   bit-serial adder and presents {carry, sum} on a valid/ready register.
//   Ports:
//     clk    rising-edge clock
//     rst    asynchronous active-low reset
//     io_bus serial_result_collector_if.slave (serial in, result out, flags)
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | waiting for a bit qualified by frame_start
//   ST_COLLECT | frame in progress; r_cnt bits already shifted in
module serial_result_collector #(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  serial_result_collector_if.slave    io_bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH:0]   r_res_data;
  logic             r_res_vld;
  logic             r_overflow;
  logic             r_frame_err;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_frame_err;
  logic             w_complete;
  logic             w_res_load;
  logic             w_drop;

  assign w_shifted = {io_bus.sin, r_shreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_frame_err = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.bit_vld) begin
          if (io_bus.frame_start) begin
            w_shreg_nxt = w_shifted;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = ST_COLLECT;
          end else begin
            w_frame_err = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (io_bus.bit_vld) begin
          if (io_bus.frame_start) begin
            // Restart: older bits are discarded, this bit becomes bit 0.
            w_frame_err = 1'b1;
            w_shreg_nxt = {io_bus.sin, {(WIDTH-1){1'b0}}};
            w_cnt_nxt   = CW'(1);
          end else begin
            w_shreg_nxt = w_shifted;
            if (r_cnt == CW'(WIDTH-1)) begin
              w_complete  = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A completed frame loads when the output slot is empty or being drained
  // in the same cycle; otherwise it is lost and flagged.
  assign w_res_load = w_complete && (!r_res_vld || io_bus.res_rdy);
  assign w_drop     = w_complete && r_res_vld && !io_bus.res_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_data  <= '0;
      r_res_vld   <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_res_load) begin
        r_res_data <= {io_bus.carry_in, w_shifted};
      end
      r_res_vld   <= w_complete || (r_res_vld && !io_bus.res_rdy);
      // Set has priority over clear.
      r_overflow  <= w_drop || (r_overflow && !io_bus.clr_err);
      r_frame_err <= w_frame_err;
    end
  end

  assign io_bus.res_data  = r_res_data;
  assign io_bus.res_vld   = r_res_vld;
  assign io_bus.overflow  = r_overflow;
  assign io_bus.frame_err = r_frame_err;
  assign io_bus.busy      = (r_state == ST_COLLECT);

endmodule

// File: tb/tb_serial_result_collector.sv
module tb_serial_result_collector;
  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  serial_result_collector_if #(.WIDTH(WIDTH)) bus ();

  serial_result_collector #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: frame bits accumulated as a weighted integer sum.
  logic           m_busy;
  int             m_idx;
  int             m_sum;
  logic [WIDTH:0] m_data;
  logic           m_vld;
  logic           m_ovf;
  logic           m_ferr;

  task automatic model_reset();
    m_busy = 1'b0; m_idx = 0; m_sum = 0;
    m_data = '0; m_vld = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic c, input logic v,
                            input logic f, input logic r, input logic cl);
    bit done;
    int newval;
    done   = 0;
    newval = 0;
    m_ferr = 1'b0;
    if (v) begin
      if (!m_busy) begin
        if (f) begin m_busy = 1'b1; m_sum = int'(s); m_idx = 1; end
        else m_ferr = 1'b1;
      end else if (f) begin
        m_ferr = 1'b1; m_sum = int'(s); m_idx = 1;
      end else begin
        m_sum = m_sum + (int'(s) << m_idx);
        m_idx = m_idx + 1;
        if (m_idx == WIDTH) begin
          done   = 1;
          m_busy = 1'b0;
          m_idx  = 0;
          newval = (int'(c) << WIDTH) + m_sum;
        end
      end
    end
    if (cl) m_ovf = 1'b0;
    if (done) begin
      if (!m_vld || r) begin m_data = newval[WIDTH:0]; m_vld = 1'b1; end
      else m_ovf = 1'b1;
    end else if (m_vld && r) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("res_data",  32'(bus.res_data),  32'(m_data));
    check("res_vld",   32'(bus.res_vld),   32'(m_vld));
    check("overflow",  32'(bus.overflow),  32'(m_ovf));
    check("frame_err", 32'(bus.frame_err), 32'(m_ferr));
    check("busy",      32'(bus.busy),      32'(m_busy));
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cyc(input logic s, input logic c, input logic v,
                     input logic f, input logic r, input logic cl);
    bus.sin = s; bus.carry_in = c; bus.bit_vld = v;
    bus.frame_start = f; bus.res_rdy = r; bus.clr_err = cl;
    @(posedge clk);
    model_step(s, c, v, f, r, cl);
    @(negedge clk);
    check_model();
  endtask

  task automatic send_frame(input int val, input logic cy, input logic r_mid,
                            input logic r_last);
    for (int i = 0; i < WIDTH; i++) begin
      logic b;
      b = val[i];
      if (i == WIDTH-1) cyc(b, cy, 1'b1, 1'b0, r_last, 1'b0);
      else              cyc(b, 1'b0, 1'b1, (i == 0), r_mid, 1'b0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    bus.sin = 0; bus.carry_in = 0; bus.bit_vld = 0;
    bus.frame_start = 0; bus.res_rdy = 0; bus.clr_err = 0;
    rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_vld",  32'(bus.res_vld),  32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 5+6: bits 1,1,0,1 carry 0
    send_frame(4'b1011, 1'b0, 1'b1, 1'b1);
    check("add_5_6", 32'(bus.res_data), 32'b01011);
    check("add_5_6_vld", 32'(bus.res_vld), 32'd1);
    cyc(0, 0, 0, 0, 1, 0);
    check("add_5_6_drained", 32'(bus.res_vld), 32'd0);

    // 15+1: all-zero sum, carry 1, two-cycle gap after bit 1
    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("gap_busy", 32'(bus.busy), 32'd1);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 1, 1, 0, 1, 0);
    check("add_15_1", 32'(bus.res_data), 32'b10000);
    cyc(0, 0, 0, 0, 1, 0);

    // Backpressure: second frame dropped
    send_frame(4'b0011, 1'b0, 1'b0, 1'b0);
    send_frame(4'b1100, 1'b0, 1'b0, 1'b0);
    check("bp_hold", 32'(bus.res_data), 32'b00011);
    check("bp_ovf",  32'(bus.overflow), 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    check("bp_clr",  32'(bus.overflow), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);
    check("bp_drain", 32'(bus.res_vld), 32'd0);

    // Consume and complete in the same cycle
    send_frame(4'b0101, 1'b1, 1'b0, 1'b0);
    send_frame(4'b1110, 1'b0, 1'b0, 1'b1);
    check("cc_vld",  32'(bus.res_vld),  32'd1);
    check("cc_data", 32'(bus.res_data), 32'b01110);
    check("cc_ovf",  32'(bus.overflow), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);

    // Framing: restart on 3rd bit, then 0,0,1 carry 1
    cyc(1, 0, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(1, 0, 1, 1, 1, 0);
    check("restart_ferr", 32'(bus.frame_err), 32'd1);
    cyc(0, 0, 1, 0, 1, 0);
    check("restart_ferr_pulse", 32'(bus.frame_err), 32'd0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(1, 1, 1, 0, 1, 0);
    check("restart_data", 32'(bus.res_data), 32'b11001);
    check("restart_idle", 32'(bus.busy), 32'd0);
    cyc(1, 0, 1, 0, 1, 0);
    check("idle_ferr", 32'(bus.frame_err), 32'd1);
    check("idle_stay", 32'(bus.busy), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);

    // Reset mid-frame with a pending result
    send_frame(4'b0110, 1'b1, 1'b0, 1'b0);
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("mr_data", 32'(bus.res_data), 32'd0);
    check("mr_vld",  32'(bus.res_vld),  32'd0);
    check("mr_busy", 32'(bus.busy),     32'd0);
    check("mr_ovf",  32'(bus.overflow), 32'd0);
    check("mr_ferr", 32'(bus.frame_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    send_frame(4'b1001, 1'b0, 1'b1, 1'b1);
    check("post_rst", 32'(bus.res_data), 32'b01001);
    cyc(0, 0, 0, 0, 1, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic s, c, v, f, r, cl;
      s  = 1'($urandom);
      c  = 1'($urandom);
      v  = ($urandom_range(0, 9) < 7);
      f  = m_busy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
      r  = 1'($urandom);
      cl = ($urandom_range(0, 9) == 0);
      cyc(s, c, v, f, r, cl);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
